// File: rtl/imem_resp_pkg.sv
// Shared constants and helpers for the instruction-memory responder.
package imem_resp_pkg;

  localparam int          IMEM_CPU_WIDTH = 32;
  localparam int          IMEM_INS_WIDTH = 32;
  localparam logic [31:0] IMEM_BASE      = 32'h8000_0000;
  localparam int          IMEM_DEPTH     = 1024;
  localparam int          IMEM_LATENCY   = 1;
  localparam int          IMEM_QDEPTH    = 2;

  // Pointer width for a queue of the given depth; a depth of 1 still needs one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// Response queue: DEPTH-entry synchronous FIFO of {err, inst} with occupancy count.
module imem_rsp_fifo
  import imem_resp_pkg::*;
#(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int PW = ptr_width(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Storage write; entries are not reset, validity comes from the count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo DEPTH; full/empty is decided by the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  // The credit scheme upstream guarantees a slot for every pipeline exit.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/imem_resp.sv
// Instruction-memory responder: word array with preload port, fault check,
// read-latency pipeline and an in-order response queue with credit flow control.
module imem_resp
  import imem_resp_pkg::*;
#(
  parameter int                   CPU_WIDTH   = IMEM_CPU_WIDTH,
  parameter int                   INS_WIDTH   = IMEM_INS_WIDTH,
  parameter logic [CPU_WIDTH-1:0] BASE_ADDR   = CPU_WIDTH'(IMEM_BASE),
  parameter int                   DEPTH_WORDS = IMEM_DEPTH,
  parameter int                   LATENCY     = IMEM_LATENCY,
  parameter int                   QDEPTH      = IMEM_QDEPTH,
  localparam int                  AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [CPU_WIDTH-1:0] i_req_addr,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [INS_WIDTH-1:0] o_rsp_inst,
  output logic                 o_rsp_err,
  input  logic                 i_ld_en,
  input  logic [AW-1:0]        i_ld_addr,
  input  logic [INS_WIDTH-1:0] i_ld_data
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int RW = INS_WIDTH + 1;

  logic [INS_WIDTH-1:0] mem [DEPTH_WORDS];
  logic [CPU_WIDTH-3:0] off_w;
  logic                 fault;
  logic [AW-1:0]        rd_idx;
  logic [RW-1:0]        rd_rsp;
  logic                 acc;
  logic                 pop;
  logic                 push;
  logic [RW-1:0]        push_rsp;
  logic [RW-1:0]        head_rsp;
  logic [CW-1:0]        q_cnt;
  logic                 q_valid;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic                 rdy_q;

  assign acc = i_req_valid & rdy_q;
  assign pop = q_valid & i_rsp_ready;

  // Word offset from the base (BASE_ADDR is word aligned); any bit above the
  // array index range means the address lies beyond the array.
  assign off_w  = i_req_addr[CPU_WIDTH-1:2] - BASE_ADDR[CPU_WIDTH-1:2];
  assign fault  = (|i_req_addr[1:0]) | (i_req_addr < BASE_ADDR) | (|off_w[CPU_WIDTH-3:AW]);
  assign rd_idx = fault ? '0 : off_w[AW-1:0];
  assign rd_rsp = fault ? {1'b1, {INS_WIDTH{1'b0}}} : {1'b0, mem[rd_idx]};

  // Preload write; the read above is captured at the same edge, so it sees the old word.
  always_ff @(posedge clk) begin
    if (i_ld_en) mem[i_ld_addr] <= i_ld_data;
  end

  // The accept edge itself is the first latency stage; LATENCY-1 registers follow.
  generate
    if (LATENCY == 1) begin : g_direct
      assign push     = acc;
      assign push_rsp = rd_rsp;
    end else begin : g_pipe
      logic [LATENCY-2:0] sv;
      logic [RW-1:0]      sd [LATENCY-1];

      // Shift valid bits (reset) and response data (no reset) one stage per cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          sv <= '0;
        end else begin
          sv[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++) sv[i] <= sv[i-1];
        end
        sd[0] <= rd_rsp;
        for (int i = 1; i < LATENCY - 1; i++) sd[i] <= sd[i-1];
      end

      assign push     = sv[LATENCY-2];
      assign push_rsp = sd[LATENCY-2];
    end
  endgenerate

  imem_rsp_fifo #(
    .WIDTH (RW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rsp),
    .pop       (pop),
    .head_data (head_rsp),
    .count     (q_cnt)
  );

  // Outstanding = in pipeline + queued; accept and pop together cancel out.
  always_comb begin
    cnt_nxt = cnt;
    if (acc && !pop)      cnt_nxt = cnt + CW'(1);
    else if (!acc && pop) cnt_nxt = cnt - CW'(1);
  end

  // Credit counter and registered ready, so ready never depends on this cycle's inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      rdy_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      rdy_q <= (cnt_nxt < CW'(QDEPTH));
    end
  end

  assign q_valid     = (q_cnt != '0);
  assign o_req_ready = rdy_q;
  assign o_rsp_valid = q_valid;
  assign o_rsp_inst  = q_valid ? head_rsp[INS_WIDTH-1:0] : '0;
  assign o_rsp_err   = q_valid & head_rsp[INS_WIDTH];

endmodule

// File: tb/tb_imem_resp.sv
// Scoreboard bench for imem_resp: default instance (LATENCY 1, QDEPTH 2) and a
// deeper instance (LATENCY 3, QDEPTH 4) for streaming throughput.
module tb_imem_resp;

  typedef struct {
    logic        err;
    logic [31:0] inst;
    int          acc;
    bit          lat;
  } exp_t;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          pops2 = 0;

  logic        req_valid = 1'b0, req_ready, rsp_valid, rsp_ready = 1'b1, rsp_err, ld_en = 1'b0;
  logic [31:0] req_addr = '0, rsp_inst, ld_data = '0;
  logic [9:0]  ld_addr = '0;

  logic        req_valid_2 = 1'b0, req_ready_2, rsp_valid_2, rsp_ready_2 = 1'b1, rsp_err_2, ld_en_2 = 1'b0;
  logic [31:0] req_addr_2 = '0, rsp_inst_2, ld_data_2 = '0;
  logic [9:0]  ld_addr_2 = '0;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imem_resp dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_inst(rsp_inst), .o_rsp_err(rsp_err),
    .i_ld_en(ld_en), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
  );

  imem_resp #(.LATENCY(3), .QDEPTH(4)) dut2 (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid_2), .o_req_ready(req_ready_2), .i_req_addr(req_addr_2),
    .o_rsp_valid(rsp_valid_2), .i_rsp_ready(rsp_ready_2), .o_rsp_inst(rsp_inst_2), .o_rsp_err(rsp_err_2),
    .i_ld_en(ld_en_2), .i_ld_addr(ld_addr_2), .i_ld_data(ld_data_2)
  );

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  // Monitor for the default instance: pops happen where valid & ready at the next edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp1_unexpected inst=%h err=%b required=no_response", rsp_inst, rsp_err);
      end else begin
        e = q1.pop_front();
        check("rsp1_inst", rsp_inst, e.inst);
        check("rsp1_err", {31'b0, rsp_err}, {31'b0, e.err});
        if (e.lat) check("rsp1_latency", 32'(cyc - e.acc), 32'd0);
      end
    end
  end

  // Monitor for the deep instance: every response must appear exactly two edges after accept.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid_2 && rsp_ready_2) begin
      pops2++;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL rsp2_unexpected inst=%h err=%b required=no_response", rsp_inst_2, rsp_err_2);
      end else begin
        e = q2.pop_front();
        check("rsp2_inst", rsp_inst_2, e.inst);
        check("rsp2_err", {31'b0, rsp_err_2}, {31'b0, e.err});
        check("rsp2_latency", 32'(cyc - e.acc), 32'd2);
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic send_ld(input logic [31:0] a, input logic e, input logic [31:0] d, input bit lat,
                         input logic le, input logic [9:0] la, input logic [31:0] ldd);
    int t;
    exp_t x;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a;
    ld_en = le; ld_addr = la; ld_data = ldd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout addr=%h ready=0 required=1", a);
    end else begin
      x.err = e; x.inst = d; x.acc = cyc + 1; x.lat = lat;
      q1.push_back(x);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; ld_en = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic e, input logic [31:0] d, input bit lat);
    send_ld(a, e, d, lat, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic drain1();
    for (int t = 0; t < 100 && q1.size() > 0; t++) @(negedge clk);
    check("drain1_left", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_inst", rsp_inst, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    check("post_rst_ready2", {31'b0, req_ready_2}, 32'd1);

    preload(10'd0, 32'h0000_0093);
    preload(10'd1, 32'h0010_0113);
    preload(10'd2, 32'h0020_0193);
    preload(10'd3, 32'h0030_0213);
    preload(10'd4, 32'h0040_0293);
    preload(10'd5, 32'h0000_0001);
    preload(10'd1023, 32'hCAFE_F00D);

    // Back-to-back fetch, ready always high
    send(BASE + 32'h0, 1'b0, 32'h0000_0093, 1'b1);
    send(BASE + 32'h4, 1'b0, 32'h0010_0113, 1'b1);
    @(negedge clk);
    check("b2b_req_ready", {31'b0, req_ready}, 32'd1);
    drain1();

    // Faults and last in-range word
    send(32'h8000_0002, 1'b1, 32'h0, 1'b1);
    send(32'h7FFF_FFFC, 1'b1, 32'h0, 1'b1);
    send(32'h8000_1000, 1'b1, 32'h0, 1'b1);
    send(32'h8000_0FFC, 1'b0, 32'hCAFE_F00D, 1'b1);
    drain1();

    // Backpressure: two accepted, third waits, head held stable
    rsp_ready = 1'b0;
    send(BASE + 32'h8, 1'b0, 32'h0020_0193, 1'b0);
    send(BASE + 32'hC, 1'b0, 32'h0030_0213, 1'b0);
    @(negedge clk);
    check("bp_req_ready", {31'b0, req_ready}, 32'd0);
    check("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    held = rsp_inst;
    check("bp_head", held, 32'h0020_0193);
    repeat (3) @(negedge clk);
    check("bp_hold_inst", rsp_inst, held);
    check("bp_hold_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(BASE + 32'h10, 1'b0, 32'h0040_0293, 1'b0);
    drain1();
    @(negedge clk);
    check("bp_ready_back", {31'b0, req_ready}, 32'd1);

    // Read-before-write on the same edge
    send_ld(BASE + 32'h14, 1'b0, 32'h0000_0001, 1'b1, 1'b1, 10'd5, 32'hDEAD_BEEF);
    send(BASE + 32'h14, 1'b0, 32'hDEAD_BEEF, 1'b1);
    drain1();

    // Reset with two outstanding discards them
    rsp_ready = 1'b0;
    send(BASE + 32'h0, 1'b0, 32'h0000_0093, 1'b0);
    send(BASE + 32'h4, 1'b0, 32'h0010_0113, 1'b0);
    rst = 1'b1;
    q1.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("mid_rst_inst", rsp_inst, 32'd0);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_back", {31'b0, req_ready}, 32'd1);
    repeat (5) @(negedge clk);
    send(BASE + 32'h4, 1'b0, 32'h0010_0113, 1'b1);
    drain1();

    // Deep instance: preload then stream eight requests
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ld_en_2 = 1'b1; ld_addr_2 = 10'(i); ld_data_2 = 32'h1000_0000 + 32'(i);
    end
    @(posedge clk); #1;
    ld_en_2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_t x;
      @(negedge clk);
      req_valid_2 = 1'b1; req_addr_2 = BASE + 32'(4 * i);
      check("stream_ready2", {31'b0, req_ready_2}, 32'd1);
      x.err = 1'b0; x.inst = 32'h1000_0000 + 32'(i); x.acc = cyc + 1; x.lat = 1'b1;
      q2.push_back(x);
    end
    @(posedge clk); #1;
    req_valid_2 = 1'b0;
    for (int t = 0; t < 100 && q2.size() > 0; t++) @(negedge clk);
    check("drain2_left", 32'(q2.size()), 32'd0);
    check("stream_pops2", 32'(pops2), 32'd8);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t required=finish", $time);
    $fatal(1);
  end

endmodule
